// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: forwarding-select
// encoding and the layout of a packed in-flight slot entry.
package hazard_scoreboard_pkg;

    // Operand source select driven to the ID/EX operand muxes
    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_EX  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_WB  = 2'd3
    } fwd_sel_e;

    // Packed slot entry layout, LSB first: valid, we, late, then waddr
    localparam int SB_VALID_BIT = 0;
    localparam int SB_WE_BIT    = 1;
    localparam int SB_LATE_BIT  = 2;
    localparam int SB_WADDR_LSB = 3;

    // Total entry width for a given register address width
    function automatic int sb_entry_w(input int addr_w);
        return SB_WADDR_LSB + addr_w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_slot.sv
// One pipeline slot of the hazard scoreboard: a packed entry register with
// synchronous clear (reset or flush), hold (downstream stall) and load.
module sb_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] slot_r;

    // Slot register: reset/clear empty it, hold freezes it, otherwise advance
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r <= {W{1'b0}};
        end else if (clr) begin
            slot_r <= {W{1'b0}};
        end else if (hold) begin
            slot_r <= slot_r;
        end else begin
            slot_r <= d;
        end
    end

    assign q = slot_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Tracks destination registers of instructions in
// EX, MEM and WB, selects per-operand forwarding sources and requests a
// load-use stall. Slots hold on a downstream stall and empty on a flush.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_WB     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  reg_read_en_1,
    input  logic [REG_ADDR_W-1:0] reg_addr_1,
    input  logic                  reg_read_en_2,
    input  logic [REG_ADDR_W-1:0] reg_addr_2,
    input  logic                  reg_write_en,
    input  logic [REG_ADDR_W-1:0] reg_write_addr,
    input  logic                  id_late_result,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  stall_req,
    output logic [1:0]            fwd_sel_1,
    output logic [1:0]            fwd_sel_2
);

    localparam int ENTRY_W = sb_entry_w(REG_ADDR_W);

    logic [ENTRY_W-1:0] id_entry_s;
    logic [ENTRY_W-1:0] ex_slot_r;
    logic [ENTRY_W-1:0] mem_slot_r;
    logic [ENTRY_W-1:0] wb_slot_r;
    logic               stall_s;
    logic [1:0]         fwd_sel_1_s;
    logic [1:0]         fwd_sel_2_s;

    // A slot supplies an operand only for a real, enabled, non-$0 read of its destination
    function automatic logic slot_hit(
        input logic                  rd_en,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [ENTRY_W-1:0]    slot
    );
        return rd_en
            && (addr != {REG_ADDR_W{1'b0}})
            && slot[SB_VALID_BIT]
            && slot[SB_WE_BIT]
            && (slot[SB_WADDR_LSB +: REG_ADDR_W] == addr);
    endfunction

    // Operand source decode with youngest-wins priority EX > MEM > WB
    function automatic fwd_sel_e operand_sel(
        input logic                  rd_en,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [ENTRY_W-1:0]    ex,
        input logic [ENTRY_W-1:0]    mem,
        input logic [ENTRY_W-1:0]    wb
    );
        fwd_sel_e sel;
        if (slot_hit(rd_en, addr, ex)) begin
            sel = SEL_EX;
        end else if (slot_hit(rd_en, addr, mem)) begin
            sel = SEL_MEM;
        end else if (slot_hit(rd_en, addr, wb)) begin
            // Write-through register file already holds the WB value
            sel = FWD_WB ? SEL_WB : SEL_RF;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Load-use hazard: a late-result producer sits in EX and ID reads its destination
    always_comb begin
        stall_s = 1'b0;
        if (id_valid && ex_slot_r[SB_LATE_BIT]) begin
            stall_s = slot_hit(reg_read_en_1, reg_addr_1, ex_slot_r)
                   || slot_hit(reg_read_en_2, reg_addr_2, ex_slot_r);
        end else begin
            stall_s = 1'b0;
        end
    end

    // Forwarding selects; always decoded, even while a stall is requested
    always_comb begin
        fwd_sel_1_s = operand_sel(reg_read_en_1, reg_addr_1, ex_slot_r, mem_slot_r, wb_slot_r);
        fwd_sel_2_s = operand_sel(reg_read_en_2, reg_addr_2, ex_slot_r, mem_slot_r, wb_slot_r);
    end

    // Entry offered to the EX slot: the ID instruction, or a bubble when stalled/invalid
    always_comb begin
        id_entry_s = {ENTRY_W{1'b0}};
        if (id_valid && !stall_s) begin
            id_entry_s[SB_VALID_BIT]                    = 1'b1;
            id_entry_s[SB_WE_BIT]                       = reg_write_en;
            id_entry_s[SB_LATE_BIT]                     = id_late_result;
            id_entry_s[SB_WADDR_LSB +: REG_ADDR_W]      = reg_write_addr;
        end else begin
            id_entry_s = {ENTRY_W{1'b0}};
        end
    end

    sb_slot #(.W(ENTRY_W)) u_ex_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (stall_in),
        .d    (id_entry_s),
        .q    (ex_slot_r)
    );

    sb_slot #(.W(ENTRY_W)) u_mem_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (stall_in),
        .d    (ex_slot_r),
        .q    (mem_slot_r)
    );

    sb_slot #(.W(ENTRY_W)) u_wb_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .hold (stall_in),
        .d    (mem_slot_r),
        .q    (wb_slot_r)
    );

    assign stall_req = stall_s;
    assign fwd_sel_1 = fwd_sel_1_s;
    assign fwd_sel_2 = fwd_sel_2_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios with
// literal expectations, then randomized traffic against a slot-list model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       reg_read_en_1;
    logic [4:0] reg_addr_1;
    logic       reg_read_en_2;
    logic [4:0] reg_addr_2;
    logic       reg_write_en;
    logic [4:0] reg_write_addr;
    logic       id_late_result;
    logic       stall_in;
    logic       flush;
    logic       stall_req;
    logic [1:0] fwd_sel_1;
    logic [1:0] fwd_sel_2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: list of in-flight instructions, index 0 = EX (youngest), 2 = WB
    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] a;
        logic       late;
    } ent_t;
    ent_t m[3];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .FWD_WB(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .reg_read_en_1  (reg_read_en_1),
        .reg_addr_1     (reg_addr_1),
        .reg_read_en_2  (reg_read_en_2),
        .reg_addr_2     (reg_addr_2),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .id_late_result (id_late_result),
        .stall_in       (stall_in),
        .flush          (flush),
        .stall_req      (stall_req),
        .fwd_sel_1      (fwd_sel_1),
        .fwd_sel_2      (fwd_sel_2)
    );

    // Youngest in-flight writer of the register decides the source
    function automatic logic [1:0] exp_sel(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (m[i].v && m[i].we && m[i].a == a) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    function automatic logic exp_stall();
        logic r1;
        logic r2;
        r1 = reg_read_en_1 && reg_addr_1 != 5'd0 && reg_addr_1 == m[0].a;
        r2 = reg_read_en_2 && reg_addr_2 != 5'd0 && reg_addr_2 == m[0].a;
        return id_valid && m[0].v && m[0].we && m[0].late && (r1 || r2);
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model advance at each clock edge
    always @(posedge clk) begin
        if (rst || flush) begin
            m[0] <= '0;
            m[1] <= '0;
            m[2] <= '0;
        end else if (!stall_in) begin
            m[2] <= m[1];
            m[1] <= m[0];
            m[0] <= (id_valid && !exp_stall())
                    ? ent_t'{1'b1, reg_write_en, reg_write_addr, id_late_result}
                    : ent_t'(0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_stall", {1'b0, stall_req}, {1'b0, exp_stall()});
            if (!exp_stall()) begin
                check("model_fwd1", fwd_sel_1, exp_sel(reg_read_en_1, reg_addr_1));
                check("model_fwd2", fwd_sel_2, exp_sel(reg_read_en_2, reg_addr_2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic e1, input logic [4:0] x1,
                          input logic e2, input logic [4:0] x2,
                          input logic we, input logic [4:0] wa, input logic late);
        id_valid       = v;
        reg_read_en_1  = e1;
        reg_addr_1     = x1;
        reg_read_en_2  = e2;
        reg_addr_2     = x2;
        reg_write_en   = we;
        reg_write_addr = wa;
        id_late_result = late;
    endtask

    task automatic clear_pipe();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        stall_in = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic rand_id();
        set_id(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 3));
    endtask

    initial begin
        m[0] = '0;
        m[1] = '0;
        m[2] = '0;
        rst      = 1'b1;
        stall_in = 1'b0;
        flush    = 1'b0;
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Reset with random ID inputs for two cycles
        tick();
        chk_en = 1'b1;
        rand_id();
        stall_in = 1'($urandom);
        tick();
        rand_id();
        stall_in = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_id(1'b1, 1'b1, 5'(a), 1'b1, 5'(31 - a), 1'b1, 5'(a), 1'b1);
            #1;
            check("reset_stall", {1'b0, stall_req}, 2'd0);
            check("reset_fwd1", fwd_sel_1, 2'd0);
            check("reset_fwd2", fwd_sel_2, 2'd0);
        end
        tick();
        rst = 1'b0;

        // ALU to ALU: addu $3,$1,$2 ; addu $4,$3,$3
        clear_pipe();
        set_id(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
        tick();
        set_id(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0);
        #1;
        check("alu_fwd1", fwd_sel_1, 2'd1);
        check("alu_fwd2", fwd_sel_2, 2'd1);
        check("alu_stall", {1'b0, stall_req}, 2'd0);

        // Load-use: lw $5,0($1) ; addu $6,$5,$0
        clear_pipe();
        set_id(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        tick();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
        #1;
        check("lu_stall_c2", {1'b0, stall_req}, 2'd1);
        tick();
        check("lu_stall_c3", {1'b0, stall_req}, 2'd0);
        check("lu_fwd1_c3", fwd_sel_1, 2'd2);
        reg_addr_2 = 5'd6;
        #1;
        check("lu_ex_bubble", fwd_sel_2, 2'd0);

        // Priority: writers of $7 in WB, MEM, EX
        clear_pipe();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        repeat (3) tick();
        set_id(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("prio_ex", fwd_sel_1, 2'd1);
        clear_pipe();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        repeat (2) tick();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0);
        tick();
        set_id(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("prio_mem", fwd_sel_1, 2'd2);
        clear_pipe();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        tick();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) tick();
        set_id(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        check("prio_wb", fwd_sel_2, 2'd3);

        // $0 never forwards or stalls; disabled read never forwards
        clear_pipe();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        set_id(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("r0_fwd1", fwd_sel_1, 2'd0);
        check("r0_fwd2", fwd_sel_2, 2'd0);
        check("r0_stall", {1'b0, stall_req}, 2'd0);
        clear_pipe();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        tick();
        set_id(1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0);
        #1;
        check("rden_off_fwd1", fwd_sel_1, 2'd0);
        check("rden_on_fwd2", fwd_sel_2, 2'd1);

        // Downstream stall holds a load in EX; flush overrides stall
        clear_pipe();
        set_id(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        tick();
        set_id(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0);
        stall_in = 1'b1;
        #1;
        check("hold_stall_0", {1'b0, stall_req}, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_stall_n", {1'b0, stall_req}, 2'd1);
        end
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        stall_in = 1'b0;
        #1;
        check("flush_stall", {1'b0, stall_req}, 2'd0);
        check("flush_fwd1", fwd_sel_1, 2'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rand_id();
            stall_in = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        stall_in = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
